exec_unit: RTL and testbench

- Execute stage of the multi-cycle processor. It sits directly downstream of the decode stage and upstream of writeback/memory.
- Accepts one decoded instruction plus fetched operands. Computes the result, updates the 5-bit PSR and resolves branch conditions.
- Performs shift/rotate iteratively, one bit per cycle.
- Presents the result to writeback over a valid/ready handshake.

---
 rtl/proc_pkg.sv | 37 +++
 rtl/psr_calc.sv | 23 ++
 rtl/exec_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_exec_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the execute stage: opcodes, branch conditions,
// PSR bit positions and the stage FSM encoding.
package proc_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_ROT = 4'd6;
  localparam logic [3:0] OP_SHF = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam logic [3:0] CC_ALW = 4'd0;
  localparam logic [3:0] CC_P   = 4'd1;
  localparam logic [3:0] CC_E   = 4'd2;
  localparam logic [3:0] CC_C   = 4'd3;
  localparam logic [3:0] CC_N   = 4'd4;
  localparam logic [3:0] CC_Z   = 4'd5;
  localparam logic [3:0] CC_NC  = 4'd6;
  localparam logic [3:0] CC_GT  = 4'd7;

  localparam int PSR_C = 0;
  localparam int PSR_P = 1;
  localparam int PSR_E = 2;
  localparam int PSR_N = 3;
  localparam int PSR_Z = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/psr_calc.sv
// Combinational PSR flag generator.
// Ports: i_result, i_carry_in, i_carry_valid -> o_flags (C only when valid).
module psr_calc
  import proc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_carry_in,
  input  logic              i_carry_valid,
  output logic [4:0]        o_flags
);

  always_comb begin
    o_flags        = '0;
    o_flags[PSR_C] = i_carry_valid & i_carry_in;
    o_flags[PSR_P] = ^i_result;
    o_flags[PSR_E] = ~i_result[0];
    o_flags[PSR_N] = i_result[DATA_W-1];
    o_flags[PSR_Z] = (i_result == '0);
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, PSR update, branch resolve, bit-serial shift/rotate.
// Ports: decoded op in (in_valid/in_ready), result out (out_valid/out_ready).
module exec_unit
  import proc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [3:0]         cc,
  input  logic               src_type,
  input  logic [FIELD_W-1:0] src_field,
  input  logic [DATA_W-1:0]  src_data,
  input  logic [DATA_W-1:0]  dest_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               result_we,
  output logic               branch_taken,
  output logic               halt,
  output logic [4:0]         psr
);

  localparam int CW = $clog2(DATA_W) + 1;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0]  r_d;
  logic [CW-1:0]      r_cnt;
  logic               r_left;
  logic               r_rot;
  logic [DATA_W-1:0]  r_result;
  logic               r_we;
  logic               r_br;
  logic               r_halt;
  logic [4:0]         r_psr;

  logic [DATA_W-1:0]  w_src;
  logic [FIELD_W-1:0] w_mag;
  logic [CW-1:0]      w_k;
  logic               w_is_sh;
  logic               w_shift_go;
  logic [DATA_W:0]    w_sum;

  logic [DATA_W-1:0]  w_res;
  logic               w_we;
  logic               w_cy;
  logic               w_cyv;
  logic               w_upd;
  logic               w_br;
  logic               w_hlt;

  logic               w_shout;
  logic               w_fill;
  logic [DATA_W-1:0]  w_shv;

  logic [DATA_W-1:0]  w_pc_res;
  logic               w_pc_cy;
  logic               w_pc_cyv;
  logic [4:0]         w_flags;
  logic [4:0]         w_psr_nxt;

  assign w_src = src_type ? DATA_W'(src_field) : src_data;

  // Count is signed: magnitude sets k, sign sets direction.
  assign w_mag = src_field[FIELD_W-1] ? (~src_field + 1'b1) : src_field;
  assign w_is_sh = (opcode == OP_ROT) || (opcode == OP_SHF);

  // SHF saturates at full width (result all fill); ROT wraps mod width.
  always_comb begin
    w_k = CW'(w_mag[CW-2:0]);
    if (opcode == OP_SHF) begin
      if (w_mag >= FIELD_W'(DATA_W)) w_k = CW'(DATA_W);
    end
  end

  assign w_shift_go = w_is_sh && (w_k != '0);
  assign w_sum = {1'b0, dest_data} + {1'b0, w_src};

  always_comb begin
    w_res = '0;
    w_we  = 1'b0;
    w_cy  = 1'b0;
    w_cyv = 1'b0;
    w_upd = 1'b0;
    w_hlt = 1'b0;
    case (opcode)
      OP_LD:  begin w_res = w_src; w_we = 1'b1; w_upd = 1'b1; end
      OP_STR: begin w_res = w_src; w_we = 1'b1; end
      OP_XOR: begin
        w_res = dest_data ^ w_src; w_we = 1'b1; w_upd = 1'b1;
      end
      OP_ADD: begin
        w_res = w_sum[DATA_W-1:0]; w_cy = w_sum[DATA_W];
        w_cyv = 1'b1; w_we = 1'b1; w_upd = 1'b1;
      end
      OP_CMP: begin w_res = ~w_src; w_we = 1'b1; w_upd = 1'b1; end
      // Zero-length shift/rotate: value passes, carry untouched.
      OP_ROT, OP_SHF: begin
        w_res = dest_data; w_we = 1'b1; w_upd = 1'b1;
      end
      OP_HLT: w_hlt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_br = 1'b0;
    if (opcode == OP_BRA) begin
      case (cc)
        CC_ALW: w_br = 1'b1;
        CC_P:   w_br = r_psr[PSR_P];
        CC_E:   w_br = r_psr[PSR_E];
        CC_C:   w_br = r_psr[PSR_C];
        CC_N:   w_br = r_psr[PSR_N];
        CC_Z:   w_br = r_psr[PSR_Z];
        CC_NC:  w_br = ~r_psr[PSR_C];
        CC_GT:  w_br = ~r_psr[PSR_N] & ~r_psr[PSR_Z];
        default: w_br = 1'b0;
      endcase
    end
  end

  assign w_shout = r_left ? r_d[DATA_W-1] : r_d[0];
  assign w_fill  = r_rot & w_shout;
  assign w_shv   = r_left ? {r_d[DATA_W-2:0], w_fill}
                          : {w_fill, r_d[DATA_W-1:1]};

  // Flags come from the final shift step while iterating, else the ALU.
  always_comb begin
    w_pc_res = w_res;
    w_pc_cy  = w_cy;
    w_pc_cyv = w_cyv;
    if (r_state == S_ITER) begin
      w_pc_res = w_shv;
      w_pc_cy  = w_shout;
      w_pc_cyv = 1'b1;
    end
  end

  psr_calc #(.DATA_W(DATA_W)) u_psr_calc (
    .i_result      (w_pc_res),
    .i_carry_in    (w_pc_cy),
    .i_carry_valid (w_pc_cyv),
    .o_flags       (w_flags)
  );

  assign w_psr_nxt = {w_flags[4:1], w_pc_cyv ? w_flags[PSR_C] : r_psr[PSR_C]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = w_shift_go ? S_ITER : S_DONE;
      end
      S_ITER: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d      <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_rot    <= 1'b0;
      r_result <= '0;
      r_we     <= 1'b0;
      r_br     <= 1'b0;
      r_halt   <= 1'b0;
      r_psr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_d    <= dest_data;
            r_cnt  <= w_k;
            r_left <= ~src_field[FIELD_W-1];
            r_rot  <= (opcode == OP_ROT);
            if (!w_shift_go) begin
              r_result <= w_res;
              r_we     <= w_we;
              r_br     <= w_br;
              r_halt   <= w_hlt;
              if (w_upd) r_psr <= w_psr_nxt;
            end
          end
        end
        S_ITER: begin
          r_d   <= w_shv;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_result <= w_shv;
            r_we     <= 1'b1;
            r_br     <= 1'b0;
            r_halt   <= 1'b0;
            r_psr    <= w_psr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign result       = r_result;
  assign result_we    = r_we;
  assign branch_taken = r_br;
  assign halt         = r_halt;
  assign psr          = r_psr;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed results, flags, latency,
// backpressure and mid-iteration reset.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  cc;
  logic        src_type;
  logic [11:0] src_field;
  logic [31:0] src_data;
  logic [31:0] dest_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        result_we;
  logic        branch_taken;
  logic        halt;
  logic [4:0]  psr;

  int n_run  = 0;
  int n_fail = 0;
  int lat;
  logic rdy_seen;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .cc           (cc),
    .src_type     (src_type),
    .src_field    (src_field),
    .src_data     (src_data),
    .dest_data    (dest_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .result_we    (result_we),
    .branch_taken (branch_taken),
    .halt         (halt),
    .psr          (psr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op and count cycles until out_valid; rdy_seen ORs
  // in_ready over the busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [3:0] c,
                        input logic st, input logic [11:0] sf,
                        input logic [31:0] sd, input logic [31:0] dd);
    opcode = op; cc = c; src_type = st; src_field = sf;
    src_data = sd; dest_data = dd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 4'hF; src_field = 12'h0; dest_data = 32'h0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy_seen = rdy_seen | in_ready;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'd0; cc = 4'd0; src_type = 1'b0; src_field = '0;
    src_data = '0; dest_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_psr", 32'(psr), 32'd0);
    chk("rst_res", result, 32'd0);

    run_op(4'd5, 4'd0, 1'b0, 12'h0, 32'h1, 32'hFFFFFFFF);
    chk("add_lat", lat, 1);
    chk("add_res", result, 32'h0);
    chk("add_we", 32'(result_we), 32'd1);
    chk("add_psr", 32'(psr), 32'b10101);
    finish_op("add");

    run_op(4'd3, 4'd5, 1'b0, 12'h0, 32'h0, 32'h0);
    chk("braz_br", 32'(branch_taken), 32'd1);
    chk("braz_we", 32'(result_we), 32'd0);
    chk("braz_psr", 32'(psr), 32'b10101);
    finish_op("braz");

    run_op(4'd3, 4'd6, 1'b0, 12'h0, 32'h0, 32'h0);
    chk("branc_br", 32'(branch_taken), 32'd0);
    finish_op("branc");

    run_op(4'd7, 4'd0, 1'b1, 12'h003, 32'h0, 32'h20000001);
    chk("shf_lat", lat, 4);
    chk("shf_busy", 32'(rdy_seen), 32'd0);
    chk("shf_res", result, 32'h00000008);
    chk("shf_psr", 32'(psr), 32'b00111);
    finish_op("shf");

    run_op(4'd6, 4'd0, 1'b1, 12'hFFC, 32'h0, 32'h0000000F);
    chk("rot_lat", lat, 5);
    chk("rot_res", result, 32'hF0000000);
    chk("rot_psr", 32'(psr), 32'b01101);
    finish_op("rot");

    run_op(4'd4, 4'd0, 1'b0, 12'h0, 32'h0F0F0F0F, 32'hA5A5A5A5);
    chk("xor_lat", lat, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_res", result, 32'hAAAAAAAA);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("xor_psr", 32'(psr), 32'b01101);
    finish_op("xor");

    run_op(4'd9, 4'd0, 1'b1, 12'h000, 32'h0, 32'h0);
    chk("cmp_res", result, 32'hFFFFFFFF);
    chk("cmp_psr", 32'(psr), 32'b01001);
    finish_op("cmp");

    run_op(4'd8, 4'd0, 1'b0, 12'h0, 32'h0, 32'h0);
    chk("hlt_h", 32'(halt), 32'd1);
    chk("hlt_we", 32'(result_we), 32'd0);
    chk("hlt_psr", 32'(psr), 32'b01001);
    finish_op("hlt");

    run_op(4'd7, 4'd0, 1'b1, 12'h021, 32'h0, 32'hFFFFFFFF);
    chk("sat_lat", lat, 33);
    chk("sat_res", result, 32'h0);
    chk("sat_psr", 32'(psr), 32'b10101);
    finish_op("sat");

    run_op(4'd6, 4'd0, 1'b1, 12'h020, 32'h0, 32'h80000000);
    chk("rot0_lat", lat, 1);
    chk("rot0_res", result, 32'h80000000);
    chk("rot0_psr", 32'(psr), 32'b01111);
    finish_op("rot0");

    opcode = 4'd7; cc = 4'd0; src_type = 1'b1; src_field = 12'h01F;
    src_data = 32'h0; dest_data = 32'h00000001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_psr", 32'(psr), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);

    run_op(4'd5, 4'd0, 1'b0, 12'h0, 32'd2, 32'd3);
    chk("add2_lat", lat, 1);
    chk("add2_res", result, 32'd5);
    chk("add2_psr", 32'(psr), 32'b00000);
    finish_op("add2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
